irq_arbiter: RTL and testbench

- Multi-source interrupt arbiter feeding the single irq/iack handshake of the pipeline control FSM.
- Edge-detects N_SRC external interrupt lines and latches each edge as a pending bit, then masks them.
- Picks the highest-priority eligible source, raises irq with a stable vector, and retires the source when the control FSM acknowledges.
- Sits between peripheral interrupt lines and the core control FSM. The vector goes to the exception/PC logic.

---
 rtl/irq_arbiter.sv | 150 +++++++++++++++
 tb/tb_irq_arbiter.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/irq_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : irq_arbiter
//  Purpose  : Multi-source interrupt arbiter. Edge-detects N_SRC interrupt
//             lines into pending bits, masks them, and presents the
//             lowest-index eligible source to the control FSM over a single
//             irq/iack handshake with a stable vector.
//  Revision : 1.0 - initial release
// ============================================================================
module irq_arbiter #(
    parameter int N_SRC = 8,
    parameter int VEC_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] src_irq,
    input  logic             mask_we,
    input  logic [N_SRC-1:0] mask_wdata,
    input  logic [N_SRC-1:0] pend_clr,
    input  logic             iack,
    output logic             irq,
    output logic [VEC_W-1:0] irq_vec,
    output logic [N_SRC-1:0] pending,
    output logic [N_SRC-1:0] mask_q,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_SVC  = 2'd2
    } state_t;

    localparam logic [N_SRC-1:0] c_MASK_RESET = '1;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_irq;
    logic               w_irq_nxt;
    logic [VEC_W-1:0]   r_vec;
    logic [VEC_W-1:0]   w_vec_nxt;
    logic [N_SRC-1:0]   r_src_q;
    logic [N_SRC-1:0]   r_pending;
    logic [N_SRC-1:0]   r_mask;
    logic               r_iack_q;

    logic [N_SRC-1:0]   w_edge;
    logic [N_SRC-1:0]   w_eligible;
    logic [N_SRC-1:0]   w_vec_onehot;
    logic [N_SRC-1:0]   w_svc_clr;
    logic [N_SRC-1:0]   w_pending_nxt;
    logic [VEC_W-1:0]   w_winner;
    logic               w_svc_take;

    // Edge detect, eligibility and the one-hot form of the held vector
    always_comb begin
        w_edge     = src_irq & ~r_src_q;
        w_eligible = r_pending & ~r_mask;
        for (int i = 0; i < N_SRC; i++) begin
            w_vec_onehot[i] = (r_vec == VEC_W'(i));
        end
    end

    // Fixed-priority encoder: lowest eligible index wins
    always_comb begin
        w_winner = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (w_eligible[i]) begin
                w_winner = VEC_W'(i);
            end
        end
    end

    // Next-state and registered-output decode for the handshake FSM
    always_comb begin
        w_state_nxt = r_state;
        w_irq_nxt   = r_irq;
        w_vec_nxt   = r_vec;
        w_svc_take  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_irq_nxt = 1'b0;
                if (|w_eligible) begin
                    w_state_nxt = S_REQ;
                    w_irq_nxt   = 1'b1;
                    w_vec_nxt   = w_winner;
                end
            end
            S_REQ: begin
                // Acknowledge is the rising edge of iack; a stale high level is not an ack
                if (iack && !r_iack_q) begin
                    w_state_nxt = S_SVC;
                    w_irq_nxt   = 1'b0;
                    w_svc_take  = 1'b1;
                end else if (!(|(w_eligible & w_vec_onehot))) begin
                    // Requested source got masked or cleared before ack: withdraw
                    w_state_nxt = S_IDLE;
                    w_irq_nxt   = 1'b0;
                end
            end
            S_SVC: begin
                w_irq_nxt = 1'b0;
                if (!iack) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_irq_nxt   = 1'b0;
            end
        endcase
    end

    // Pending update: a new edge beats any clear on the same bit
    always_comb begin
        w_svc_clr     = w_vec_onehot & {N_SRC{w_svc_take}};
        w_pending_nxt = (r_pending & ~pend_clr & ~w_svc_clr) | w_edge;
    end

    // State, mask, pending and line history registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_irq     <= 1'b0;
            r_vec     <= '0;
            r_pending <= '0;
            r_mask    <= c_MASK_RESET;
            r_src_q   <= src_irq;
            r_iack_q  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_irq     <= w_irq_nxt;
            r_vec     <= w_vec_nxt;
            r_pending <= w_pending_nxt;
            r_src_q   <= src_irq;
            r_iack_q  <= iack;
            if (mask_we) begin
                r_mask <= mask_wdata;
            end
        end
    end

    assign irq     = r_irq;
    assign irq_vec = r_vec;
    assign pending = r_pending;
    assign mask_q  = r_mask;
    assign busy    = (r_state == S_REQ) || (r_state == S_SVC);

endmodule
`default_nettype wire

// File: tb/tb_irq_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_irq_arbiter
//  Purpose  : Directed, table-driven bench for irq_arbiter with hand-written
//             sequences for withdraw, re-trigger, reset-held lines and abort.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_irq_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] src_irq;
    logic       mask_we;
    logic [7:0] mask_wdata;
    logic [7:0] pend_clr;
    logic       iack;
    logic       irq;
    logic [2:0] irq_vec;
    logic [7:0] pending;
    logic [7:0] mask_q;
    logic       busy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       rst;
        logic [7:0] src;
        logic       mwe;
        logic [7:0] mwd;
        logic [7:0] pclr;
        logic       iack;
        logic       e_irq;
        logic [2:0] e_vec;
        logic [7:0] e_pend;
        logic [7:0] e_mask;
        logic       e_busy;
    } vec_t;

    vec_t tbl [18];

    irq_arbiter #(.N_SRC(8), .VEC_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .src_irq    (src_irq),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .pend_clr   (pend_clr),
        .iack       (iack),
        .irq        (irq),
        .irq_vec    (irq_vec),
        .pending    (pending),
        .mask_q     (mask_q),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Apply one cycle of inputs, clock once, then compare all outputs
    task automatic cyc(input string name,
                       input logic r, input logic [7:0] s, input logic mwe,
                       input logic [7:0] mwd, input logic [7:0] pc, input logic ack,
                       input logic e_irq, input logic [2:0] e_vec,
                       input logic [7:0] e_pend, input logic [7:0] e_mask,
                       input logic e_busy);
        rst        = r;
        src_irq    = s;
        mask_we    = mwe;
        mask_wdata = mwd;
        pend_clr   = pc;
        iack       = ack;
        @(posedge clk);
        #1;
        total++;
        if ({irq, irq_vec, pending, mask_q, busy} !== {e_irq, e_vec, e_pend, e_mask, e_busy}) begin
            bad++;
            $display("FAIL %s: got irq=%b vec=%0d pend=%h mask=%h busy=%b, want irq=%b vec=%0d pend=%h mask=%h busy=%b",
                     name, irq, irq_vec, pending, mask_q, busy,
                     e_irq, e_vec, e_pend, e_mask, e_busy);
        end
    endtask

    initial begin
        rst = 1'b0; src_irq = '0; mask_we = 1'b0; mask_wdata = '0; pend_clr = '0; iack = 1'b0;

        // {rst, src, mwe, mwd, pclr, iack, irq, vec, pend, mask, busy}
        tbl[0]  = '{1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 8'hFF, 1'b0};
        tbl[1]  = '{1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 8'hFF, 1'b0};
        tbl[2]  = '{1'b1, 8'h00, 1'b1, 8'hFE, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 8'hFE, 1'b0};
        tbl[3]  = '{1'b1, 8'h01, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 3'd0, 8'h01, 8'hFE, 1'b0};
        tbl[4]  = '{1'b1, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 3'd0, 8'h01, 8'hFE, 1'b1};
        tbl[5]  = '{1'b1, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00, 8'hFE, 1'b1};
        tbl[6]  = '{1'b1, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00, 8'hFE, 1'b1};
        tbl[7]  = '{1'b1, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 8'hFE, 1'b0};
        tbl[8]  = '{1'b1, 8'h00, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0};
        tbl[9]  = '{1'b1, 8'h24, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 3'd0, 8'h24, 8'h00, 1'b0};
        tbl[10] = '{1'b1, 8'h24, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 3'd2, 8'h24, 8'h00, 1'b1};
        tbl[11] = '{1'b1, 8'h24, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 3'd2, 8'h20, 8'h00, 1'b1};
        tbl[12] = '{1'b1, 8'h24, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 3'd2, 8'h20, 8'h00, 1'b0};
        tbl[13] = '{1'b1, 8'h24, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 3'd5, 8'h20, 8'h00, 1'b1};
        tbl[14] = '{1'b1, 8'h24, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 3'd5, 8'h00, 8'h00, 1'b1};
        tbl[15] = '{1'b1, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 3'd5, 8'h00, 8'h00, 1'b0};
        tbl[16] = '{1'b1, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 3'd5, 8'h00, 8'h00, 1'b0};
        tbl[17] = '{1'b1, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 3'd5, 8'h00, 8'h00, 1'b0};

        #2;
        for (int i = 0; i < 18; i++) begin
            cyc($sformatf("tbl[%0d]", i), tbl[i].rst, tbl[i].src, tbl[i].mwe, tbl[i].mwd,
                tbl[i].pclr, tbl[i].iack,
                tbl[i].e_irq, tbl[i].e_vec, tbl[i].e_pend, tbl[i].e_mask, tbl[i].e_busy);
        end

        // Masking the outstanding request withdraws it but keeps pending
        cyc("wd_edge",   1, 8'h08, 0, 8'h00, 8'h00, 0,  0, 3'd5, 8'h08, 8'h00, 0);
        cyc("wd_req",    1, 8'h00, 0, 8'h00, 8'h00, 0,  1, 3'd3, 8'h08, 8'h00, 1);
        cyc("wd_mask",   1, 8'h00, 1, 8'h08, 8'h00, 0,  1, 3'd3, 8'h08, 8'h08, 1);
        cyc("wd_drop",   1, 8'h00, 0, 8'h00, 8'h00, 0,  0, 3'd3, 8'h08, 8'h08, 0);
        cyc("wd_stay",   1, 8'h00, 0, 8'h00, 8'h00, 0,  0, 3'd3, 8'h08, 8'h08, 0);
        cyc("wd_unmask", 1, 8'h00, 1, 8'h00, 8'h00, 0,  0, 3'd3, 8'h08, 8'h00, 0);
        cyc("wd_rereq",  1, 8'h00, 0, 8'h00, 8'h00, 0,  1, 3'd3, 8'h08, 8'h00, 1);
        cyc("wd_ack",    1, 8'h00, 0, 8'h00, 8'h00, 1,  0, 3'd3, 8'h00, 8'h00, 1);
        cyc("wd_rel",    1, 8'h00, 0, 8'h00, 8'h00, 0,  0, 3'd3, 8'h00, 8'h00, 0);

        // Re-trigger of the serviced source during SVC, then set-beats-clear
        cyc("rt_edge",   1, 8'h02, 0, 8'h00, 8'h00, 0,  0, 3'd3, 8'h02, 8'h00, 0);
        cyc("rt_req",    1, 8'h00, 0, 8'h00, 8'h00, 0,  1, 3'd1, 8'h02, 8'h00, 1);
        cyc("rt_ack",    1, 8'h00, 0, 8'h00, 8'h00, 1,  0, 3'd1, 8'h00, 8'h00, 1);
        cyc("rt_svc_edge",1,8'h02, 0, 8'h00, 8'h00, 1,  0, 3'd1, 8'h02, 8'h00, 1);
        cyc("rt_svc_hold",1,8'h00, 0, 8'h00, 8'h00, 1,  0, 3'd1, 8'h02, 8'h00, 1);
        cyc("rt_rel",    1, 8'h00, 0, 8'h00, 8'h00, 0,  0, 3'd1, 8'h02, 8'h00, 0);
        cyc("rt_req2",   1, 8'h00, 0, 8'h00, 8'h00, 0,  1, 3'd1, 8'h02, 8'h00, 1);
        cyc("rt_setwin", 1, 8'h02, 0, 8'h00, 8'h02, 0,  1, 3'd1, 8'h02, 8'h00, 1);
        cyc("rt_swclr",  1, 8'h00, 0, 8'h00, 8'h02, 0,  1, 3'd1, 8'h00, 8'h00, 1);
        cyc("rt_wdraw",  1, 8'h00, 0, 8'h00, 8'h00, 0,  0, 3'd1, 8'h00, 8'h00, 0);

        // Line held high through reset release produces no edge
        cyc("hr_rst",    0, 8'h10, 0, 8'h00, 8'h00, 0,  0, 3'd0, 8'h00, 8'hFF, 0);
        cyc("hr_rel",    1, 8'h10, 0, 8'h00, 8'h00, 0,  0, 3'd0, 8'h00, 8'hFF, 0);
        cyc("hr_hold",   1, 8'h10, 0, 8'h00, 8'h00, 0,  0, 3'd0, 8'h00, 8'hFF, 0);
        cyc("hr_low",    1, 8'h00, 0, 8'h00, 8'h00, 0,  0, 3'd0, 8'h00, 8'hFF, 0);
        cyc("hr_rise",   1, 8'h10, 0, 8'h00, 8'h00, 0,  0, 3'd0, 8'h10, 8'hFF, 0);
        cyc("hr_clr",    1, 8'h10, 0, 8'h00, 8'h10, 0,  0, 3'd0, 8'h00, 8'hFF, 0);
        cyc("hr_noedge", 1, 8'h10, 0, 8'h00, 8'h00, 0,  0, 3'd0, 8'h00, 8'hFF, 0);

        // Reset while in SVC with other sources pending aborts everything
        cyc("ab_unmask", 1, 8'h00, 1, 8'h00, 8'h00, 0,  0, 3'd0, 8'h00, 8'h00, 0);
        cyc("ab_edge",   1, 8'h01, 0, 8'h00, 8'h00, 0,  0, 3'd0, 8'h01, 8'h00, 0);
        cyc("ab_req",    1, 8'h00, 0, 8'h00, 8'h00, 0,  1, 3'd0, 8'h01, 8'h00, 1);
        cyc("ab_ack",    1, 8'h00, 0, 8'h00, 8'h00, 1,  0, 3'd0, 8'h00, 8'h00, 1);
        cyc("ab_pend30", 1, 8'h30, 0, 8'h00, 8'h00, 1,  0, 3'd0, 8'h30, 8'h00, 1);
        cyc("ab_reset",  0, 8'h30, 0, 8'h00, 8'h00, 1,  0, 3'd0, 8'h00, 8'hFF, 0);
        cyc("ab_after",  1, 8'h30, 0, 8'h00, 8'h00, 0,  0, 3'd0, 8'h00, 8'hFF, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
